// File: rtl/shift_seq_pkg.sv
// Shared types and constants for the multicycle shift sequencer.
// Used by shift_step_unit and shift_sequencer.
package shift_seq_pkg;

   localparam int unsigned DATA_W_DEF = 32;
   localparam int unsigned AMT_W_DEF  = $clog2(DATA_W_DEF);
   localparam int unsigned LUI_SHAMT  = 16;

   typedef enum logic [1:0] {
      OP_SLL  = 2'b00,
      OP_SRL  = 2'b01,
      OP_SRA  = 2'b10,
      OP_RSVD = 2'b11
   } shift_op_e;

   typedef enum logic [1:0] {
      SRC_B     = 2'b00,
      SRC_16    = 2'b01,
      SRC_INSTR = 2'b10
   } amt_src_e;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      LOAD  = 2'b01,
      SHIFT = 2'b10,
      DONE  = 2'b11
   } state_e;

endpackage

// File: rtl/shift_step_unit.sv
// Combinational single-step shifter: moves the working value by 1 or 4 bits
// according to the latched operation. The reserved op passes the value through.
module shift_step_unit
   import shift_seq_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF
) (
   input  shift_op_e         op,
   input  logic              step4,
   input  logic [DATA_W-1:0] work_in,
   output logic [DATA_W-1:0] work_out
);

   // one shift step, fill bits chosen by the operation
   always_comb begin
      work_out = work_in;
      case (op)
         OP_SLL: begin
            if (step4) work_out = {work_in[DATA_W-5:0], 4'b0000};
            else       work_out = {work_in[DATA_W-2:0], 1'b0};
         end
         OP_SRL: begin
            if (step4) work_out = {4'b0000, work_in[DATA_W-1:4]};
            else       work_out = {1'b0, work_in[DATA_W-1:1]};
         end
         OP_SRA: begin
            if (step4) work_out = {{4{work_in[DATA_W-1]}}, work_in[DATA_W-1:4]};
            else       work_out = {work_in[DATA_W-1], work_in[DATA_W-1:1]};
         end
         default: work_out = work_in;
      endcase
   end

endmodule

// File: rtl/shift_sequencer.sv
// Multicycle shift controller: IDLE -> LOAD -> SHIFT* -> DONE.
// Define SHIFT_SEQ_STEP4_EN to move 4 bits per SHIFT cycle while count>=4.
module shift_sequencer
   import shift_seq_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned AMT_W  = $clog2(DATA_W)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [1:0]        shift_op,
   input  logic [1:0]        amt_src,
   input  logic [DATA_W-1:0] data_in,
   input  logic [AMT_W-1:0]  amt_in,
   output logic [1:0]        sll_src_b,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] result
);

   localparam logic [AMT_W-1:0] STEP_ONE  = AMT_W'(1);
   localparam logic [AMT_W-1:0] STEP_FOUR = AMT_W'(4);
   localparam logic [AMT_W-1:0] AMT_ZERO  = {AMT_W{1'b0}};

   state_e              state_r;
   state_e              state_s;
   shift_op_e           op_r;
   logic [DATA_W-1:0]   work_r;
   logic [DATA_W-1:0]   work_step_s;
   logic [DATA_W-1:0]   result_r;
   logic [AMT_W-1:0]    count_r;
   logic [AMT_W-1:0]    count_next_s;
   logic [AMT_W-1:0]    step_amt_s;
   logic [1:0]          sll_src_b_r;
   logic                busy_r;
   logic                done_r;
   logic                step4_s;

`ifdef SHIFT_SEQ_STEP4_EN
   assign step4_s = (count_r >= STEP_FOUR);
`else
   assign step4_s = 1'b0;
`endif

   assign step_amt_s   = step4_s ? STEP_FOUR : STEP_ONE;
   assign count_next_s = count_r - step_amt_s;

   shift_step_unit #(
      .DATA_W (DATA_W)
   ) u_step (
      .op       (op_r),
      .step4    (step4_s),
      .work_in  (work_r),
      .work_out (work_step_s)
   );

   // next-state decode
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (start) state_s = LOAD;
            else       state_s = IDLE;
         end
         LOAD: begin
            if (amt_in == AMT_ZERO || op_r == OP_RSVD) state_s = DONE;
            else                                       state_s = SHIFT;
         end
         SHIFT: begin
            if (count_next_s == AMT_ZERO) state_s = DONE;
            else                          state_s = SHIFT;
         end
         DONE:    state_s = IDLE;
         default: state_s = IDLE;
      endcase
   end

   // state, datapath and registered outputs; reset aborts any command in flight
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_r     <= IDLE;
         op_r        <= OP_SLL;
         work_r      <= {DATA_W{1'b0}};
         result_r    <= {DATA_W{1'b0}};
         count_r     <= AMT_ZERO;
         sll_src_b_r <= 2'b00;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
      end else begin
         state_r <= state_s;
         busy_r  <= (state_s != IDLE);
         done_r  <= (state_s == DONE);
         case (state_r)
            IDLE: begin
               if (start) begin
                  work_r      <= data_in;
                  op_r        <= shift_op_e'(shift_op);
                  sll_src_b_r <= amt_src;
               end
            end
            LOAD: begin
               count_r <= amt_in;
               if (state_s == DONE) result_r <= work_r;
            end
            SHIFT: begin
               work_r  <= work_step_s;
               count_r <= count_next_s;
               if (state_s == DONE) result_r <= work_step_s;
            end
            default: begin
               count_r <= count_r;
            end
         endcase
      end
   end

   assign sll_src_b = sll_src_b_r;
   assign busy      = busy_r;
   assign done      = done_r;
   assign result    = result_r;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed self-checking bench for shift_sequencer; expected results and
// latencies are hand-computed constants (latency formula follows SHIFT_SEQ_STEP4_EN).
module tb_shift_sequencer;

   logic        clk;
   logic        reset;
   logic        start;
   logic [1:0]  shift_op;
   logic [1:0]  amt_src;
   logic [31:0] data_in;
   logic [4:0]  amt_in;
   logic [1:0]  sll_src_b;
   logic        busy;
   logic        done;
   logic [31:0] result;

   int total;
   int bad;

   shift_sequencer dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .shift_op  (shift_op),
      .amt_src   (amt_src),
      .data_in   (data_in),
      .amt_in    (amt_in),
      .sll_src_b (sll_src_b),
      .busy      (busy),
      .done      (done),
      .result    (result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
      end
   endtask

   function automatic int exp_lat(input logic [1:0] op, input int n);
      if (op == 2'b11 || n == 0) return 2;
`ifdef SHIFT_SEQ_STEP4_EN
      return 2 + n / 4 + n % 4;
`else
      return 2 + n;
`endif
   endfunction

   // issue one command, then observe cycles c1..c(lat+2) at the falling edge
   task automatic run_cmd(input string name, input logic [1:0] op, input logic [1:0] src,
                          input logic [4:0] amt, input logic [31:0] data,
                          input logic [31:0] exp_res, input int repulse);
      int lat;
      int done_cyc;
      int pulses;
      int busy_last;
      lat       = exp_lat(op, int'(amt));
      done_cyc  = 0;
      pulses    = 0;
      busy_last = 0;
      @(negedge clk);
      shift_op = op;
      amt_src  = src;
      data_in  = data;
      amt_in   = amt;
      start    = 1'b1;
      for (int c = 1; c <= lat + 2; c++) begin
         @(negedge clk);
         start = (c == repulse);
         if (c == repulse) begin
            shift_op = 2'b01;
            data_in  = 32'hFFFF_FFFF;
         end
         if (c == 1) begin
            check({name, " sll_src_b c1"}, {30'd0, sll_src_b}, {30'd0, src});
            check({name, " busy c1"}, {31'd0, busy}, 32'd1);
         end
         if (done) begin
            pulses++;
            if (done_cyc == 0) done_cyc = c;
         end
         if (busy) busy_last = c;
      end
      start = 1'b0;
      check({name, " done cycle"}, 32'(done_cyc), 32'(lat));
      check({name, " done pulses"}, 32'(pulses), 32'd1);
      check({name, " busy last cycle"}, 32'(busy_last), 32'(lat));
      check({name, " result"}, result, exp_res);
      check({name, " sll_src_b held"}, {30'd0, sll_src_b}, {30'd0, src});
   endtask

   initial begin
      int pulses;
      total    = 0;
      bad      = 0;
      reset    = 1'b0;
      start    = 1'b0;
      shift_op = 2'b00;
      amt_src  = 2'b00;
      data_in  = 32'd0;
      amt_in   = 5'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset busy", {31'd0, busy}, 32'd0);
      check("reset done", {31'd0, done}, 32'd0);
      check("reset result", result, 32'd0);
      check("reset sll_src_b", {30'd0, sll_src_b}, 32'd0);
      reset = 1'b1;

      run_cmd("sll3",    2'b00, 2'b00, 5'd3,  32'h0000_0001, 32'h0000_0008, 0);
      run_cmd("sll16",   2'b00, 2'b01, 5'd16, 32'h0000_ABCD, 32'hABCD_0000, 0);
      run_cmd("sra31",   2'b10, 2'b10, 5'd31, 32'h8000_0000, 32'hFFFF_FFFF, 0);
      run_cmd("srl31",   2'b01, 2'b10, 5'd31, 32'h8000_0000, 32'h0000_0001, 0);
      run_cmd("sra0",    2'b10, 2'b00, 5'd0,  32'h0000_1234, 32'h0000_1234, 0);
      run_cmd("rsvd",    2'b11, 2'b00, 5'd5,  32'h0000_DEAD, 32'h0000_DEAD, 0);
      run_cmd("src11",   2'b00, 2'b11, 5'd0,  32'h0000_00F0, 32'h0000_00F0, 0);
      run_cmd("sra4",    2'b10, 2'b00, 5'd4,  32'hF000_0010, 32'hFF00_0001, 0);
      run_cmd("srl5",    2'b01, 2'b00, 5'd5,  32'h8000_0000, 32'h0400_0000, 0);
      run_cmd("restart", 2'b00, 2'b00, 5'd8,  32'h0000_0001, 32'h0000_0100, 3);
      run_cmd("doneSt",  2'b00, 2'b01, 5'd2,  32'h0000_0003, 32'h0000_000C,
              exp_lat(2'b00, 2));

      // abort in the middle of a long shift
      @(negedge clk);
      shift_op = 2'b00;
      amt_src  = 2'b10;
      data_in  = 32'h0000_0001;
      amt_in   = 5'd20;
      start    = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      check("abort busy before", {31'd0, busy}, 32'd1);
      reset = 1'b0;
      @(negedge clk);
      check("abort busy", {31'd0, busy}, 32'd0);
      check("abort done", {31'd0, done}, 32'd0);
      check("abort result", result, 32'd0);
      check("abort sll_src_b", {30'd0, sll_src_b}, 32'd0);
      reset  = 1'b1;
      pulses = 0;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         if (done || busy) pulses++;
      end
      check("abort no activity", 32'(pulses), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
